// File: rtl/run_ctrl_config.sv
// ============================================================================
// Module   : run_ctrl_config (package)
// Purpose  : Shared state encoding and run-length width for run_controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package run_ctrl_config;

    localparam int MAX_RUN_TIME_DEFAULT = 1024;

    // Wide enough to hold MAX_RUN_TIME itself, not just MAX_RUN_TIME-1.
    localparam int RUN_W = $clog2(MAX_RUN_TIME_DEFAULT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_EMIT  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/run_controller.sv
// ============================================================================
// Module   : run_controller
// Purpose  : Gates network timesteps for a bounded run window, then hands the
//            decoded result to the sink (emit) or discards it (clear).
//            Optional overrun detection is enabled with RUN_CTRL_OVERRUN_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module run_controller
    import run_ctrl_config::*;
#(
    parameter int MAX_RUN_TIME = 1024,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_clr,
    input  logic [RUN_W-1:0] cmd_run_len,
    input  logic             abort,
    input  logic             step_fire,
    output logic             net_en,
    input  logic             dec_ready,
    output logic             out_ready,
    output logic             clr,
    output logic             busy,
    output logic [CNT_W-1:0] runs_done,
    output logic             overrun
);

    localparam logic [RUN_W-1:0] MAX_LEN = RUN_W'(MAX_RUN_TIME);

    state_t           state_q, state_d;
    logic [RUN_W-1:0] len_q;
    logic [RUN_W-1:0] step_cnt_q;
    logic [CNT_W-1:0] runs_done_q;
    logic             last_step;
    logic             accept_run;

    assign last_step  = step_fire && (step_cnt_q == (len_q - RUN_W'(1)));
    assign accept_run = (state_q == ST_IDLE) && cmd_valid && !abort && !cmd_clr
                        && (cmd_run_len != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (abort) begin
                    state_d = ST_CLEAR;
                end else if (cmd_valid) begin
                    if (cmd_clr)                  state_d = ST_CLEAR;
                    else if (cmd_run_len == '0)   state_d = ST_EMIT;
                    else                          state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort)          state_d = ST_CLEAR;
                else if (last_step) state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (abort)          state_d = ST_CLEAR;
                else if (dec_ready) state_d = ST_IDLE;
            end
            ST_CLEAR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Pulses are masked while rst is high so a window dropped by reset leaves no trace.
    always_comb begin
        cmd_ready = rst || ((state_q == ST_IDLE) && !abort);
        net_en    = !rst && (state_q == ST_RUN);
        out_ready = !rst && (state_q == ST_EMIT) && dec_ready && !abort;
        clr       = !rst && (state_q == ST_CLEAR);
        busy      = !rst && (state_q != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q       <= '0;
            step_cnt_q  <= '0;
            runs_done_q <= '0;
        end else begin
            if (accept_run) begin
                len_q      <= (cmd_run_len > MAX_LEN) ? MAX_LEN : cmd_run_len;
                step_cnt_q <= '0;
            end else if ((state_q == ST_RUN) && step_fire) begin
                step_cnt_q <= step_cnt_q + RUN_W'(1);
            end
            if (out_ready) begin
                runs_done_q <= runs_done_q + CNT_W'(1);
            end
        end
    end

    assign runs_done = runs_done_q;

`ifdef RUN_CTRL_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (step_fire && !net_en) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

`default_nettype wire
